// File: rtl/zbus_initiator.sv
// ZX-bus initiator: turns req/ack transactions into Z80-style memory/IO cycles with
// programmable setup/strobe/hold timing and WAIT; define ZBUS_INIT_TIMEOUT_EN for a WAIT timeout.
module zbus_initiator #(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 2,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        io,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [7:0]  rdata,
  output logic [15:0] za,
  output logic [7:0]  zd_out,
  output logic        zd_oe,
  input  logic [7:0]  zd_in,
  output logic        ziorq_n,
  output logic        zmreq_n,
  output logic        zrd_n,
  output logic        zwr_n,
  input  logic        zwait_n
);

`ifdef ZBUS_INIT_TIMEOUT_EN
  localparam int CNT_W = 5;
  localparam int TO_W  = 9;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);
`else
  localparam int CNT_W = 4;
`endif

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  if (SETUP_CYC == 0 || SETUP_CYC > 16 || STROBE_CYC == 0 || STROBE_CYC > 16 ||
      HOLD_CYC == 0 || HOLD_CYC > 16 || TIMEOUT_CYC == 0 || TIMEOUT_CYC > 256) begin : g_param_check
    $error("zbus_initiator: timing parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic             lat_io;
`ifdef ZBUS_INIT_TIMEOUT_EN
  logic [TO_W-1:0]  tcnt;
  logic             to_flag;
`endif

  always_ff @(posedge fclk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_we  <= 1'b0;
      lat_io  <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= 8'h00;
      za      <= 16'h0000;
      zd_out  <= 8'h00;
      zd_oe   <= 1'b0;
      ziorq_n <= 1'b1;
      zmreq_n <= 1'b1;
      zrd_n   <= 1'b1;
      zwr_n   <= 1'b1;
`ifdef ZBUS_INIT_TIMEOUT_EN
      tcnt    <= '0;
      to_flag <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          // ack gating guarantees at least one idle cycle between transactions
          if (req && !ack) begin
            lat_we <= we;
            lat_io <= io;
            za     <= addr;
            zd_out <= wdata;
            zd_oe  <= we;
            cnt    <= SETUP_LD;
            busy   <= 1'b1;
            state  <= SETUP;
`ifdef ZBUS_INIT_TIMEOUT_EN
            to_flag <= 1'b0;
`endif
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            ziorq_n <= !lat_io;
            zmreq_n <= lat_io;
            zrd_n   <= lat_we;
            zwr_n   <= !lat_we;
            cnt     <= STROBE_LD;
            state   <= STROBE;
`ifdef ZBUS_INIT_TIMEOUT_EN
            tcnt    <= '0;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          // WAIT only stretches the strobe once the base count has run out
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (zwait_n) begin
            if (!lat_we) rdata <= zd_in;
            {ziorq_n, zmreq_n, zrd_n, zwr_n} <= 4'hF;
            cnt   <= HOLD_LD;
            state <= HOLD;
          end
`ifdef ZBUS_INIT_TIMEOUT_EN
          else if (tcnt == TO_LIM) begin
            if (!lat_we) rdata <= 8'hFF;
            {ziorq_n, zmreq_n, zrd_n, zwr_n} <= 4'hF;
            to_flag <= 1'b1;
            cnt     <= HOLD_LD;
            state   <= HOLD;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (cnt == '0) begin
            zd_oe <= 1'b0;
            ack   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef ZBUS_INIT_TIMEOUT_EN
            err   <= to_flag;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zbus_initiator.sv
// Scoreboard bench for zbus_initiator: a cycle-number reference model predicts bus strobes,
// ack timing, rdata and err; a negedge monitor compares every cycle and pops on ack.
module tb_zbus_initiator;
  localparam int S  = 1;
  localparam int ST = 2;
  localparam int H  = 1;
  localparam int TO = 8;
`ifdef ZBUS_INIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        fclk, rst, req, we, io;
  logic [15:0] addr, za;
  logic [7:0]  wdata, rdata, zd_out, zd_in;
  logic        ack, err, busy, zd_oe, ziorq_n, zmreq_n, zrd_n, zwr_n, zwait_n;

  zbus_initiator #(.SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H), .TIMEOUT_CYC(TO)) dut (
    .fclk(fclk), .rst(rst), .req(req), .we(we), .io(io), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .busy(busy), .rdata(rdata), .za(za), .zd_out(zd_out),
    .zd_oe(zd_oe), .zd_in(zd_in), .ziorq_n(ziorq_n), .zmreq_n(zmreq_n), .zrd_n(zrd_n),
    .zwr_n(zwr_n), .zwait_n(zwait_n)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  // cyc == k just before posedge number k; bus inputs are functions of cyc
  int cyc = 0;
  always @(posedge fclk) cyc <= cyc + 1;

  int       wlo = 0, whi = -1;
  bit       din_force = 1'b0;
  logic [7:0] din_val = 8'h00;

  function automatic logic [7:0] pat(input int c);
    return 8'((c * 29 + 7) ^ (c >>> 2));
  endfunction
  function automatic logic [7:0] din_at(input int c);
    return din_force ? din_val : pat(c);
  endfunction
  function automatic bit low(input int e);
    return (e >= wlo) && (e <= whi);
  endfunction

  assign zwait_n = !((cyc >= wlo) && (cyc <= whi));
  assign zd_in   = din_at(cyc);

  // reference model of the transaction currently on the bus
  int t_k = -100, t_x = -100, t_end = -100, t_abort = 1 << 30;
  logic t_we = 1'b0, t_io = 1'b0, t_err = 1'b0;
  logic [15:0] t_addr = 16'h0, p_addr = 16'h0;
  logic [7:0]  t_wd = 8'h0, p_wd = 8'h0, m_rdata = 8'h0;

  typedef struct {
    int         ack_cyc;
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  exp_t sb[$];
  int   ack_log[$];

  int errors = 0, checks = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic abort_run(input string name);
    errors++;
    checks++;
    $display("FAIL %s at cyc %0d: DUT did not return to idle, expected idle within bound", name, cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // monitor: per-cycle bus expectations plus scoreboard pop on ack
  always @(negedge fclk) begin
    int c;
    bit live, intx, strb, ack_e;
    logic [7:0] cv_e, cv_a;
    logic [15:0] za_e;
    logic [7:0] zd_e;
    exp_t e;
    if (mon_on) begin
      c     = cyc;
      live  = c < t_abort;
      intx  = live && (c >= t_k + 1) && (c <= t_end);
      strb  = live && (c >= t_k + S + 1) && (c <= t_x);
      ack_e = live && (c == t_end + 1);
      cv_e = {intx, ack_e, ack_e & t_err, ~(strb & t_io), ~(strb & ~t_io),
              ~(strb & ~t_we), ~(strb & t_we), intx & t_we};
      cv_a = {busy, ack, err, ziorq_n, zmreq_n, zrd_n, zwr_n, zd_oe};
      chk("ctrl{busy,ack,err,iorq,mreq,rd,wr,oe}", cv_a, cv_e);
      za_e = (c >= t_abort) ? 16'h0 : ((c >= t_k + 1) ? t_addr : p_addr);
      zd_e = (c >= t_abort) ? 8'h0 : ((c >= t_k + 1) ? t_wd : p_wd);
      chk("za", za, za_e);
      chk("zd_out", zd_out, zd_e);
      if (ack === 1'b1) begin
        ack_log.push_back(c);
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_ack at cyc %0d: got ack=1, expected no ack", c);
        end else begin
          e = sb.pop_front();
          chk("ack_cyc", c, e.ack_cyc);
          chk("rdata", rdata, e.rdata);
          chk("err", err, e.err);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic i, input logic [15:0] a, input logic [7:0] d,
                       input bit use_wait, input int wrel, input int wlen, input bit keep, input bit push);
    int   guard, k, base, e, n;
    bit   to;
    exp_t x;
    guard = 0;
    while (!(busy === 1'b0 && ack === 1'b0)) begin
      @(negedge fclk); #1;
      guard++;
      if (guard > 300) abort_run("idle_wait");
    end
    k    = cyc;
    base = k + S + ST;
    if (use_wait) begin
      wlo = base + wrel;
      whi = wlo + wlen - 1;
    end else begin
      wlo = 0;
      whi = -1;
    end
    e = base;
    n = 0;
    while (low(e) && (!TO_EN || n < TO)) begin
      e++;
      n++;
    end
    to = TO_EN && low(e);
    p_addr = t_addr; p_wd = t_wd;
    t_addr = a; t_wd = d; t_we = w; t_io = i;
    t_k = k; t_x = e; t_end = e + H; t_err = to; t_abort = 1 << 30;
    if (!w) m_rdata = to ? 8'hFF : din_at(e);
    if (push) begin
      x.ack_cyc = t_end + 1;
      x.rdata   = m_rdata;
      x.err     = to;
      sb.push_back(x);
    end
    req = 1'b1; we = w; io = i; addr = a; wdata = d;
    @(negedge fclk); #1;
    if (!keep) req = 1'b0;
    we = 1'($urandom); io = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge fclk); #1;
    while (!(busy === 1'b0 && ack === 1'b0)) begin
      @(negedge fclk); #1;
      g++;
      if (g > 300) abort_run("wait_idle");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog at cyc %0d: got no finish, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int sz;
    rst = 1'b1; req = 1'b0; we = 1'b0; io = 1'b0; addr = 16'h0; wdata = 8'h0;
    repeat (3) @(negedge fclk);
    chk("rst_ziorq_n", ziorq_n, 1); chk("rst_zmreq_n", zmreq_n, 1);
    chk("rst_zrd_n", zrd_n, 1);     chk("rst_zwr_n", zwr_n, 1);
    chk("rst_zd_oe", zd_oe, 0);     chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);         chk("rst_busy", busy, 0);
    chk("rst_za", za, 0);           chk("rst_zd_out", zd_out, 0);
    chk("rst_rdata", rdata, 0);
    #1;
    rst = 1'b0;
    mon_on = 1'b1;

    // IO write, memory read with fixed bus data, IO read stretched by WAIT
    issue(1'b1, 1'b1, 16'h80AB, 8'h5A, 1'b0, 0, 0, 1'b0, 1'b1);
    din_force = 1'b1; din_val = 8'h3C;
    issue(1'b0, 1'b0, 16'h4000, 8'h00, 1'b0, 0, 0, 1'b0, 1'b1);
    wait_idle();
    din_force = 1'b0;
    chk("mem_read_rdata", rdata, 8'h3C);
    issue(1'b0, 1'b1, 16'h00FE, 8'h11, 1'b1, 0, 3, 1'b0, 1'b1);

    // WAIT lows before the base count expires are ignored (fully / partly)
    issue(1'b0, 1'b0, 16'h0123, 8'h22, 1'b1, -2, 2, 1'b0, 1'b1);
    issue(1'b1, 1'b1, 16'hBEEF, 8'hC3, 1'b1, -1, 3, 1'b0, 1'b1);

    // req held high across three transactions
    issue(1'b0, 1'b1, 16'h1111, 8'h00, 1'b0, 0, 0, 1'b1, 1'b1);
    issue(1'b1, 1'b0, 16'h2222, 8'h77, 1'b0, 0, 0, 1'b1, 1'b1);
    issue(1'b0, 1'b0, 16'h3333, 8'h00, 1'b0, 0, 0, 1'b0, 1'b1);
    wait_idle();
    sz = ack_log.size();
    if (sz >= 3) begin
      chk("b2b_spacing_1", ack_log[sz-2] - ack_log[sz-3], S + ST + H + 2);
      chk("b2b_spacing_2", ack_log[sz-1] - ack_log[sz-2], S + ST + H + 2);
    end else begin
      errors++;
      checks++;
      $display("FAIL b2b_ack_count: got %0d acks, expected at least 3", sz);
    end

    // reset during STROBE of a write, then a normal transaction
    issue(1'b1, 1'b0, 16'h1234, 8'hA5, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge fclk); #1;
    rst = 1'b1;
    t_abort = cyc + 1;
    @(negedge fclk); #1;
    rst = 1'b0;
    t_addr = 16'h0; p_addr = 16'h0; t_wd = 8'h0; p_wd = 8'h0; m_rdata = 8'h0;
    chk("midrst_busy", busy, 0);
    chk("midrst_strobes", {ziorq_n, zmreq_n, zrd_n, zwr_n}, 4'hF);
    chk("midrst_zd_oe", zd_oe, 0);
    chk("midrst_ack", ack, 0);
    issue(1'b1, 1'b0, 16'h5678, 8'h96, 1'b0, 0, 0, 1'b0, 1'b1);

    // long WAIT on a read: timeout with the feature, indefinite stretch without
    issue(1'b0, 1'b1, 16'h00F0, 8'h00, 1'b1, 0, 20, 1'b0, 1'b1);
`ifndef ZBUS_INIT_TIMEOUT_EN
    repeat (12) @(negedge fclk);
    #1;
    chk("long_wait_busy", busy, 1);
    chk("long_wait_no_ack", ack, 0);
`endif
    wait_idle();
`ifdef ZBUS_INIT_TIMEOUT_EN
    chk("timeout_rdata", rdata, 8'hFF);
`endif
    issue(1'b1, 1'b0, 16'h0F0F, 8'h3E, 1'b1, 0, 12, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int  r, wrel, wlen;
      bit  keep;
      r    = int'($urandom_range(0, 9));
      wrel = int'($urandom_range(0, 5)) - 3;
      wlen = (r == 9) ? int'($urandom_range(8, 14)) : int'($urandom_range(1, 6));
      keep = (i < 39) && ($urandom_range(0, 3) == 0);
      issue(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), r >= 5, wrel, wlen, keep, 1'b1);
    end
    wait_idle();
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
